// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input conditioner: channel debounce states
// and the tick prescaler width.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_WHI = 2'd1,
        S_HI  = 2'd2,
        S_WLO = 2'd3
    } ch_state_t;

    // Never returns 0 so a TICK_CYCLES of 1 still yields a legal vector.
    function automatic int unsigned presc_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioning channel: 2-flop synchroniser followed by a tick-timed
// debounce FSM with registered level and single-cycle rise/fall pulses.
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_T = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_T - 1);

    logic [1:0] sync;
    logic       s;
    ch_state_t  state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       level_nx, rise_nx, fall_nx;

    assign s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            state <= S_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    // A bounce takes priority over a coincident tick: the count is not advanced.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        unique case (state)
            S_LO: begin
                if (s) begin
                    state_nx = S_WHI;
                    cnt_nx   = '0;
                end
            end
            S_WHI: begin
                if (!s) begin
                    state_nx = S_LO;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nx = S_HI;
                        cnt_nx   = '0;
                        level_nx = 1'b1;
                        rise_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            S_HI: begin
                if (!s) begin
                    state_nx = S_WLO;
                    cnt_nx   = '0;
                end
            end
            S_WLO: begin
                if (s) begin
                    state_nx = S_HI;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nx = S_LO;
                        cnt_nx   = '0;
                        level_nx = 1'b0;
                        fall_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            default: state_nx = S_LO;
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for the hit switches and start/mode button: shared
// debounce tick, per-channel debounce, and button press/short/long detection.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned N_SW        = 8,
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned DEBOUNCE_T  = 20,
    parameter int unsigned LONG_T      = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            btn_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic            btn_level,
    output logic            btn_press,
    output logic            btn_short,
    output logic            btn_long
);

    localparam int unsigned PW         = presc_width(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [15:0]   LONG_LAST  = 16'(LONG_T - 1);

    logic [PW-1:0]   presc;
    logic            tick;
    logic [N_SW-1:0] sw_fall_unused;
    logic            btn_fall;
    logic [15:0]     hold_cnt;
    logic            long_done;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_ch #(.DEBOUNCE_T(DEBOUNCE_T)) u_sw (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[i]),
            .tick  (tick),
            .level (sw_level[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall_unused[i])
        );
    end

    debounce_ch #(.DEBOUNCE_T(DEBOUNCE_T)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw),
        .tick  (tick),
        .level (btn_level),
        .rise  (btn_press),
        .fall  (btn_fall)
    );

    // hold_cnt stops advancing once long_done is set, which is its saturation point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            btn_long  <= 1'b0;
            btn_short <= 1'b0;
        end else begin
            btn_long  <= 1'b0;
            btn_short <= 1'b0;
            if (btn_press) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (btn_level && tick && !long_done) begin
                hold_cnt <= hold_cnt + 16'd1;
                if (hold_cnt == LONG_LAST) begin
                    btn_long  <= 1'b1;
                    long_done <= 1'b1;
                end
            end
            if (btn_fall) begin
                btn_short <= !long_done;
                long_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus pushes expected pulse events
// with cycle windows; a monitor pops and checks every observed pulse.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_raw;
    logic       btn_raw;
    logic [7:0] sw_level, sw_rise;
    logic       btn_level, btn_press, btn_short, btn_long;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic [10:0] pat;
        int unsigned lo;
        int unsigned hi;
        string       name;
    } exp_t;

    exp_t sb[$];

    input_conditioner #(
        .N_SW        (8),
        .TICK_CYCLES (4),
        .DEBOUNCE_T  (3),
        .LONG_T      (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_short (btn_short),
        .btn_long  (btn_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // pat = {sw_rise[7:0], btn_press, btn_short, btn_long}; window relative to now
    task automatic push(input logic [10:0] pat, input int unsigned lo_off,
                        input int unsigned hi_off, input string nm);
        exp_t e;
        e.pat  = pat;
        e.lo   = cyc + lo_off;
        e.hi   = cyc + hi_off;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [10:0] obs;
        exp_t        e;
        obs = {sw_rise, btn_press, btn_short, btn_long};
        if (obs != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got 0x%0h expected none (cycle %0d)", obs, cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_pattern"}, 32'(obs), 32'(e.pat));
                n_checks++;
                if (cyc < e.lo || cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL %s_timing: got cycle %0d expected %0d..%0d", e.name, cyc, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        sw_raw  = '0;
        btn_raw = 1'b0;
        wait_clk(2);
        check("reset_sw", {16'd0, sw_level, sw_rise}, 32'd0);
        check("reset_btn", {28'd0, btn_level, btn_press, btn_short, btn_long}, 32'd0);
        rst = 1'b0;
        wait_clk(3);

        // 1: clean rise on bit 2
        sw_raw[2] = 1'b1;
        push({8'h04, 3'b000}, 12, 15, "t1_rise2");
        wait_clk(20);
        check("t1_level", 32'(sw_level), 32'h04);

        // 2: bit 5 bouncing every 5 clk, then settled high
        for (int i = 0; i < 12; i++) begin
            sw_raw[5] = ~sw_raw[5];
            wait_clk(5);
        end
        check("t2_no_accept", 32'(sw_level), 32'h04);
        sw_raw[5] = 1'b1;
        push({8'h20, 3'b000}, 12, 15, "t2_rise5");
        wait_clk(20);
        check("t2_level", 32'(sw_level), 32'h24);

        // 3: long hold fires btn_long, release gives no short
        btn_raw = 1'b1;
        push({8'h00, 3'b100}, 12, 15, "t3_press");
        push({8'h00, 3'b001}, 52, 55, "t3_long");
        wait_clk(200);
        check("t3_level_held", 32'(btn_level), 32'd1);
        btn_raw = 1'b0;
        wait_clk(25);
        check("t3_level_rel", 32'(btn_level), 32'd0);

        // 4: short hold gives press then short, no long
        btn_raw = 1'b1;
        push({8'h00, 3'b100}, 12, 15, "t4_press");
        wait_clk(20);
        btn_raw = 1'b0;
        push({8'h00, 3'b010}, 13, 16, "t4_short");
        wait_clk(25);
        check("t4_level_rel", 32'(btn_level), 32'd0);

        // 5: all switches rise together
        sw_raw = '0;
        wait_clk(25);
        check("t5_all_low", 32'(sw_level), 32'h00);
        sw_raw = 8'hFF;
        push({8'hFF, 3'b000}, 12, 15, "t5_rise_all");
        wait_clk(20);
        check("t5_level", 32'(sw_level), 32'hFF);

        // 6: reset while bit 0 is mid-debounce and button is held
        sw_raw = '0;
        wait_clk(25);
        btn_raw = 1'b1;
        push({8'h00, 3'b100}, 12, 15, "t6_press");
        wait_clk(20);
        sw_raw[0] = 1'b1;
        wait_clk(6);
        check("t6_pre_rst_btn", 32'(btn_level), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {16'd0, sw_level, btn_level, btn_press, btn_short, btn_long, 4'd0}, 32'd0);
        wait_clk(2);
        rst = 1'b0;
        push({8'h01, 3'b100}, 12, 15, "t6_restart");
        wait_clk(14);
        check("t6_levels", {23'd0, sw_level, btn_level}, {23'd0, 8'h01, 1'b1});
        btn_raw = 1'b0;
        sw_raw  = '0;
        push({8'h00, 3'b010}, 13, 16, "t6_short");
        wait_clk(25);
        check("t6_final_levels", {23'd0, sw_level, btn_level}, 32'd0);

        wait_clk(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
